clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl.sv | 153 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Time-of-day set/run controller: 1 s prescaler, debounced mode/increment keys,
// and a RUN/SET_H/SET_M/SET_S state machine that issues load commands to the counter.
module clock_set_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int DB_CYC   = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_mode,
    input  logic        key_inc,
    input  logic [16:0] cur_sec,
    output logic        load_en,
    output logic [16:0] load_val,
    output logic        tick,
    output logic [1:0]  mode,
    output logic        blink
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(DB_CYC + 1);
    localparam logic [16:0] SEC_MAX = 17'd86399;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    logic [1:0] key_raw;
    logic [1:0] press;

    assign key_raw = {key_inc, key_mode};

    // Per key: two-stage synchronizer, then a counter that only accepts a new
    // level after it has been seen for DB_CYC consecutive cycles.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            logic          sync1_reg;
            logic          sync2_reg;
            logic          level_reg;
            logic          press_reg;
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    level_reg <= 1'b1;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= key_raw[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg != level_reg) begin
                        if (cnt_reg == CW'(DB_CYC - 1)) begin
                            level_reg <= sync2_reg;
                            cnt_reg   <= '0;
                            press_reg <= ~sync2_reg;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    state_t        state_reg;
    state_t        state_next;
    logic [PW-1:0] presc_reg;
    logic          tick_reg;
    logic          blink_reg;
    logic          load_en_reg;
    logic [16:0]   load_val_reg;

    logic          wrap;
    logic          mode_press;
    logic          inc_press;
    logic [16:0]   rem_hour;
    logic [16:0]   rem_min;
    logic [16:0]   run_val;
    logic [16:0]   inc_val;

    assign wrap       = (presc_reg == PW'(TICK_DIV - 1));
    assign mode_press = press[0];
    assign inc_press  = press[1];

    always_comb begin
        state_next = mode_press ? state_t'(state_reg + 2'd1) : state_reg;
        rem_hour   = cur_sec % 17'd3600;
        rem_min    = cur_sec % 17'd60;
        run_val    = (cur_sec >= SEC_MAX) ? 17'd0 : cur_sec + 17'd1;
        inc_val    = 17'd0;
        // Each SET field wraps within itself; out-of-range input recovers to 0.
        if (cur_sec <= SEC_MAX) begin
            case (state_reg)
                SET_H:   inc_val = (cur_sec < 17'd82800) ? cur_sec + 17'd3600 : cur_sec - 17'd82800;
                SET_M:   inc_val = (rem_hour >= 17'd3540) ? cur_sec - 17'd3540 : cur_sec + 17'd60;
                SET_S:   inc_val = (rem_min == 17'd59) ? cur_sec - 17'd59 : cur_sec + 17'd1;
                default: inc_val = 17'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            presc_reg    <= '0;
            tick_reg     <= 1'b0;
            blink_reg    <= 1'b0;
            load_en_reg  <= 1'b0;
            load_val_reg <= '0;
        end else begin
            state_reg   <= state_next;
            tick_reg    <= wrap && (state_reg == RUN);
            load_en_reg <= 1'b0;

            // Leaving SET_S restarts the second so the first tick is a full period away.
            if ((mode_press && state_reg == SET_S) || wrap) begin
                presc_reg <= '0;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end

            if (state_next == RUN) begin
                blink_reg <= 1'b0;
            end else if (wrap) begin
                blink_reg <= ~blink_reg;
            end

            if (state_reg == RUN) begin
                if (wrap) begin
                    load_en_reg  <= 1'b1;
                    load_val_reg <= run_val;
                end
            end else if (inc_press && !mode_press) begin
                load_en_reg  <= 1'b1;
                load_val_reg <= inc_val;
            end
        end
    end

    assign load_en  = load_en_reg;
    assign load_val = load_val_reg;
    assign tick     = tick_reg;
    assign mode     = state_reg;
    assign blink    = blink_reg;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with TICK_DIV=4, DB_CYC=3: load values
// are scoreboarded through a queue, increments are driven from a vector table.
module tb_clock_set_ctrl;
    localparam int TICK_DIV = 4;
    localparam int DB_CYC   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_mode = 1'b1;
    logic        key_inc = 1'b1;
    logic [16:0] cur_sec = '0;
    logic        load_en;
    logic [16:0] load_val;
    logic        tick;
    logic [1:0]  mode;
    logic        blink;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [16:0] exp_q[$];
    bit          run_phase = 1'b0;
    logic [16:0] run_exp = '0;
    int          load_cnt = 0;
    int          exp_mode = 0;

    typedef struct {
        int          m;
        logic [16:0] cur;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[13];

    clock_set_ctrl #(.TICK_DIV(TICK_DIV), .DB_CYC(DB_CYC)) dut (
        .clk(clk), .rst(rst), .key_mode(key_mode), .key_inc(key_inc),
        .cur_sec(cur_sec), .load_en(load_en), .load_val(load_val),
        .tick(tick), .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Load monitor: RUN loads against run_exp, SET loads against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (load_en) begin
                load_cnt++;
                if (run_phase) check("run_load_val", load_val, run_exp);
                else if (exp_q.size() == 0) check("spurious_load_en", load_en, 0);
                else check("inc_load_val", load_val, exp_q.pop_front());
            end
            if (!run_phase && tick) check("tick_in_set", tick, 0);
        end
    end

    task automatic press(input bit is_inc, input int hold);
        if (is_inc) key_inc = 1'b0;
        else key_mode = 1'b0;
        repeat (hold) @(negedge clk);
        key_inc  = 1'b1;
        key_mode = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic goto_mode(input int target);
        while (exp_mode != target) begin
            press(1'b0, 6);
            exp_mode = (exp_mode + 1) % 4;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int gap;
        int lc;
        int toggles;
        logic prev;

        vecs[0]  = '{1, 17'd83000, 17'd200};
        vecs[1]  = '{1, 17'd0,     17'd3600};
        vecs[2]  = '{1, 17'd82799, 17'd86399};
        vecs[3]  = '{1, 17'd86399, 17'd3599};
        vecs[4]  = '{1, 17'd90000, 17'd0};
        vecs[5]  = '{2, 17'd3599,  17'd59};
        vecs[6]  = '{2, 17'd0,     17'd60};
        vecs[7]  = '{2, 17'd86399, 17'd82859};
        vecs[8]  = '{2, 17'd7260,  17'd7320};
        vecs[9]  = '{3, 17'd119,   17'd60};
        vecs[10] = '{3, 17'd0,     17'd1};
        vecs[11] = '{3, 17'd86399, 17'd86340};
        vecs[12] = '{3, 17'd100000, 17'd0};

        repeat (3) @(negedge clk);
        check("rst_mode", mode, 0);
        check("rst_load_en", load_en, 0);
        check("rst_load_val", load_val, 0);
        check("rst_tick", tick, 0);
        check("rst_blink", blink, 0);

        // RUN at end of day: every tick carries a load back to midnight.
        cur_sec = 17'd86399;
        run_exp = 17'd0;
        run_phase = 1'b1;
        rst = 1'b0;
        t = 0;
        while (!tick && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("first_tick_seen", tick, 1);
        for (int k = 0; k < 3; k++) begin
            check("load_with_tick", load_en, 1);
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!tick && gap < 20);
            check("tick_period", gap, 4);
        end

        // Enter SET_H; time frozen and blink toggling every wrap.
        goto_mode(1);
        check("enter_set_h", mode, 1);
        repeat (2) @(negedge clk);
        run_phase = 1'b0;
        prev = blink;
        toggles = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (blink != prev) toggles++;
            prev = blink;
        end
        check("blink_toggles", toggles, 4);

        for (int i = 0; i < 13; i++) begin
            goto_mode(vecs[i].m);
            check($sformatf("vec%0d_mode", i), mode, vecs[i].m);
            cur_sec = vecs[i].cur;
            exp_q.push_back(vecs[i].exp);
            lc = load_cnt;
            press(1'b1, 6);
            check($sformatf("vec%0d_loads", i), load_cnt - lc, 1);
            check($sformatf("vec%0d_queue", i), exp_q.size(), 0);
        end

        // Debounce in SET_S: short glitch ignored, long hold gives one load.
        cur_sec = 17'd5;
        lc = load_cnt;
        key_inc = 1'b0;
        repeat (2) @(negedge clk);
        key_inc = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_no_load", load_cnt - lc, 0);
        exp_q.push_back(17'd6);
        press(1'b1, 20);
        check("hold_one_load", load_cnt - lc, 1);

        // Exit to RUN: first tick exactly TICK_DIV cycles after mode returns to 0.
        cur_sec = 17'd100;
        run_exp = 17'd101;
        run_phase = 1'b1;
        key_mode = 1'b0;
        t = 0;
        while (mode != 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("exit_mode", mode, 0);
        gap = 0;
        while (!tick && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        check("exit_first_tick", gap, 4);
        key_mode = 1'b1;
        repeat (8) @(negedge clk);
        exp_mode = 0;

        // Coincident mode and inc presses in SET_H: mode wins, no load.
        goto_mode(1);
        repeat (2) @(negedge clk);
        run_phase = 1'b0;
        check("coll_pre_mode", mode, 1);
        lc = load_cnt;
        key_mode = 1'b0;
        key_inc = 1'b0;
        repeat (6) @(negedge clk);
        key_mode = 1'b1;
        key_inc = 1'b1;
        repeat (8) @(negedge clk);
        exp_mode = 2;
        check("coll_mode", mode, 2);
        check("coll_no_load", load_cnt - lc, 0);

        // Reset in SET_M while blink is high.
        t = 0;
        while (!blink && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("blink_before_rst", blink, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_set_mode", mode, 0);
        check("rst_set_blink", blink, 0);
        check("rst_set_load_en", load_en, 0);

        // Key held through reset release: press only after the debounce window.
        key_mode = 1'b0;
        repeat (2) @(negedge clk);
        cur_sec = 17'd10;
        run_exp = 17'd11;
        run_phase = 1'b1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("held_no_early_press", mode, 0);
        repeat (3) @(negedge clk);
        check("held_press_after_db", mode, 1);
        key_mode = 1'b1;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
